// File: rtl/digit_scan_mux_pkg.sv
// digit_scan_mux_pkg: shared FSM state, segment table and display constants.
package digit_scan_mux_pkg;
  typedef enum logic {ST_GAP, ST_DRIVE} state_e;
  localparam int NUM_DIGITS = 5;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Active-low {g,f,e,d,c,b,a} hex glyphs 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/digit_scan_mux_seg7_decode.sv
// seg7_decode: digit value to active-low segments, dash for values outside the radix.
module seg7_decode import digit_scan_mux_pkg::*; #(
  parameter int base_p = 10,
  parameter int w_p = $clog2(base_p)
) (
  input  logic [w_p-1:0] value_i,
  output logic [6:0]     seg_o
);
  localparam logic [4:0] BASE = 5'(base_p);
  logic [3:0] v4;
  assign v4 = 4'(value_i);
  assign seg_o = {1'b0, v4} >= BASE ? SEG_DASH : SEG_TABLE[v4];
endmodule

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: five-digit multiplexed seven-segment scanner with gap, snapshot and leading-zero blanking.
module digit_scan_mux import digit_scan_mux_pkg::*; #(
  parameter int base_p = 10,
  parameter int scan_div_p = 50000,
  parameter int gap_p = 500
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [$clog2(base_p)-1:0]  count0_i,
  input  logic [$clog2(base_p)-1:0]  count1_i,
  input  logic [$clog2(base_p)-1:0]  count2_i,
  input  logic [$clog2(base_p)-1:0]  count3_i,
  input  logic [$clog2(base_p)-1:0]  count4_i,
  input  logic                       lzb_i,
  output logic [6:0]                 seg_o,
  output logic [4:0]                 an_o,
  output logic                       frame_o
);
  localparam int W = $clog2(base_p);
  localparam int MAXC = scan_div_p > gap_p ? scan_div_p : gap_p;
  localparam int CW = $clog2(MAXC + 1);
  typedef logic [NUM_DIGITS-1:0][W-1:0] snap_t;
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] idx_q, idx_d;
  snap_t snap_q, snap_d;
  logic lzb_q, lzb_d;
  logic [6:0] seg_q, seg_d, dec;
  logic [4:0] an_q, an_d;
  logic frame_q, last, cap, blank;
  logic [NUM_DIGITS-1:0] hz;
  logic [W-1:0] digit;
  // Segments for the next digit are decoded from the next-state snapshot so capture and display share one edge
  always_comb begin
    last = state_q == ST_GAP ? cnt_q == CW'(gap_p - 1) : cnt_q == CW'(scan_div_p - 1);
    idx_d = state_q == ST_GAP && last ? (idx_q == 3'd4 ? 3'd0 : idx_q + 3'd1) : idx_q;
    cap = state_q == ST_GAP && last && idx_d == 3'd0;
    snap_d = cap ? {count4_i, count3_i, count2_i, count1_i, count0_i} : snap_q;
    lzb_d = cap ? lzb_i : lzb_q;
    hz[4] = snap_d[4] == '0;
    for (int i = 3; i >= 0; i--) hz[i] = hz[i+1] && snap_d[i] == '0;
    digit = snap_d[idx_d];
    blank = lzb_d && idx_d != 3'd0 && hz[idx_d];
    seg_d = blank ? SEG_BLANK : dec;
    an_d = ~(5'd1 << idx_d);
  end
  seg7_decode #(.base_p(base_p)) u_dec (
    .value_i(digit),
    .seg_o  (dec)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_GAP;
      cnt_q <= '0;
      idx_q <= 3'd4;
      snap_q <= '0;
      lzb_q <= 1'b0;
      seg_q <= SEG_BLANK;
      an_q <= '1;
      frame_q <= 1'b0;
    end else begin
      cnt_q <= last ? '0 : cnt_q + CW'(1);
      frame_q <= cap;
      idx_q <= idx_d;
      snap_q <= snap_d;
      lzb_q <= lzb_d;
      if (last) begin
        state_q <= state_q == ST_GAP ? ST_DRIVE : ST_GAP;
        seg_q <= state_q == ST_GAP ? seg_d : SEG_BLANK;
        an_q <= state_q == ST_GAP ? an_d : '1;
      end
    end
  end
  assign seg_o = seg_q;
  assign an_o = an_q;
  assign frame_o = frame_q;
endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: directed checks of scan timing, snapshot, blanking and radix handling.
module tb_digit_scan_mux;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [3:0] c0 = '0, c1 = '0, c2 = '0, c3 = '0, c4 = '0;
  logic lzb_i = 1'b0;
  logic [6:0] seg10, seg16;
  logic [4:0] an10, an16;
  logic fr10, fr16;
  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  digit_scan_mux #(.base_p(10), .scan_div_p(4), .gap_p(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .count0_i(c0), .count1_i(c1), .count2_i(c2),
    .count3_i(c3), .count4_i(c4), .lzb_i(lzb_i), .seg_o(seg10), .an_o(an10), .frame_o(fr10)
  );
  digit_scan_mux #(.base_p(16), .scan_div_p(4), .gap_p(2)) dut16 (
    .clk_i(clk_i), .rst_i(rst_i), .count0_i(c0), .count1_i(c1), .count2_i(c2),
    .count3_i(c3), .count4_i(c4), .lzb_i(lzb_i), .seg_o(seg16), .an_o(an16), .frame_o(fr16)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_counts(input logic [3:0] v4, v3, v2, v1, v0, input logic lz);
    c4 = v4; c3 = v3; c2 = v2; c1 = v1; c0 = v0; lzb_i = lz;
  endtask

  task automatic wait_frame(input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = fr10;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s wait_frame: frame_o=%b after 40 cycles, required 1", name, fr10);
    end
  endtask

  // Entered at the sample right after a frame edge; walks the full 30-cycle frame and the next frame edge
  task automatic scan_check(input logic [4:0][6:0] e10, input logic [4:0][6:0] e16, input string name);
    for (int s = 0; s < 30; s++) begin
      int n = s / 6;
      bit drv = (s % 6) < 4;
      logic [4:0] ea = drv ? ~(5'd1 << n) : 5'h1F;
      logic [6:0] es10 = drv ? e10[n] : 7'h7F;
      logic [6:0] es16 = drv ? e16[n] : 7'h7F;
      logic ef = s == 0;
      checks++;
      if ({an10, seg10, fr10} !== {ea, es10, ef}) begin
        errors++;
        $display("FAIL %s b10 s=%0d: an=%b seg=%h frame=%b, required an=%b seg=%h frame=%b",
                 name, s, an10, seg10, fr10, ea, es10, ef);
      end
      checks++;
      if ({an16, seg16, fr16} !== {ea, es16, ef}) begin
        errors++;
        $display("FAIL %s b16 s=%0d: an=%b seg=%h frame=%b, required an=%b seg=%h frame=%b",
                 name, s, an16, seg16, fr16, ea, es16, ef);
      end
      tick();
    end
    checks++;
    if (fr10 !== 1'b1) begin
      errors++;
      $display("FAIL %s period: frame_o=%b 30 cycles later, required 1", name, fr10);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({an10, seg10, fr10} !== {5'h1F, 7'h7F, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: an=%b seg=%h frame=%b, required 11111 7f 0", an10, seg10, fr10);
    end
    rst_i = 1'b0;
    tick();
    checks++;
    if ({an10, seg10, fr10} !== {5'h1F, 7'h7F, 1'b0}) begin
      errors++;
      $display("FAIL reset_gap1: an=%b seg=%h frame=%b, required 11111 7f 0", an10, seg10, fr10);
    end
    tick();
    checks++;
    if ({an10, seg10, fr10} !== {5'h1E, 7'h40, 1'b1}) begin
      errors++;
      $display("FAIL reset_first_drive: an=%b seg=%h frame=%b, required 11110 40 1", an10, seg10, fr10);
    end
    tick();
    rst_i = 1'b1;
    #1;
    checks++;
    if ({an10, seg10, fr10} !== {5'h1F, 7'h7F, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: an=%b seg=%h frame=%b, required 11111 7f 0", an10, seg10, fr10);
    end
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    checks++;
    if ({an10, fr10} !== {5'h1F, 1'b0}) begin
      errors++;
      $display("FAIL reset_release_gap: an=%b frame=%b, required 11111 0", an10, fr10);
    end
    tick();
    checks++;
    if ({an10, fr10} !== {5'h1E, 1'b1}) begin
      errors++;
      $display("FAIL reset_release_drive: an=%b frame=%b, required 11110 1", an10, fr10);
    end
  endtask

  task automatic test_scan();
    set_counts(4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 1'b0);
    wait_frame("scan");
    scan_check({7'h12, 7'h19, 7'h30, 7'h24, 7'h79}, {7'h12, 7'h19, 7'h30, 7'h24, 7'h79}, "scan");
  endtask

  task automatic test_snapshot();
    set_counts(4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0);
    wait_frame("snap");
    checks++;
    if ({an10, seg10} !== {5'h1E, 7'h79}) begin
      errors++;
      $display("FAIL snap_old: an=%b seg=%h, required 11110 79", an10, seg10);
    end
    for (int i = 0; i < 12; i++) tick();
    c0 = 4'd8;
    checks++;
    if ({an10, seg10} !== {5'h1B, 7'h40}) begin
      errors++;
      $display("FAIL snap_mid: an=%b seg=%h, required 11011 40", an10, seg10);
    end
    for (int i = 0; i < 18; i++) tick();
    checks++;
    if ({an10, seg10, fr10} !== {5'h1E, 7'h00, 1'b1}) begin
      errors++;
      $display("FAIL snap_new: an=%b seg=%h frame=%b, required 11110 00 1", an10, seg10, fr10);
    end
  endtask

  task automatic test_lzb();
    set_counts(4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1);
    wait_frame("lzb");
    scan_check({7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}, "lzb");
  endtask

  task automatic test_all_zero();
    set_counts(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    wait_frame("zero_lzb");
    lzb_i = 1'b0;
    scan_check({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, "zero_lzb");
    scan_check({7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, "zero_nolzb");
  endtask

  task automatic test_range();
    set_counts(4'd0, 4'd0, 4'd12, 4'd0, 4'd0, 1'b0);
    wait_frame("range");
    scan_check({7'h40, 7'h40, 7'h3F, 7'h40, 7'h40}, {7'h40, 7'h40, 7'h46, 7'h40, 7'h40}, "range");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_lzb();
    test_all_zero();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/digit_scan_mux.md
DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 The block SHALL have parameter base_p, default 10, the digit radix, legal range 2..16.
REQ-002 The block SHALL have parameter scan_div_p, default 50000, the clock cycles each digit is driven.
REQ-003 The block SHALL have parameter gap_p, default 500, the all-off cycles between digits; legal range at least 1.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports count0_i..count4_i, input, $clog2(base_p) bits each: digit values, count0_i least significant.
REQ-007 The block SHALL have port lzb_i, input, 1 bit: leading-zero blanking enable.
REQ-008 The block SHALL have port seg_o, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-009 The block SHALL have port an_o, output, 5 bits: digit enables, active-low; bit n selects digit n.
REQ-010 The block SHALL have port frame_o, output, 1 bit: one-cycle pulse on each digit snapshot.

Function
REQ-011 The block SHALL implement a two-state FSM, GAP and DRIVE, with a prescaler counter and a digit index 0..4.
REQ-012 GAP SHALL last exactly gap_p cycles with an_o=5'b11111 and seg_o=7'h7F.
REQ-013 DRIVE SHALL last exactly scan_div_p cycles with exactly one an_o bit low, at the current index.
REQ-014 On GAP->DRIVE the index SHALL advance: 4 wraps to 0, and after reset the first DRIVE is index 0.
REQ-015 On the edge entering DRIVE for index 0, all five inputs SHALL be captured into a snapshot register and frame_o SHALL pulse high for that one cycle.
REQ-016 The displayed digits SHALL come only from the snapshot, so input changes mid-frame are invisible until the next capture.
REQ-017 The frame period SHALL be 5*(scan_div_p+gap_p) cycles.
REQ-018 seg_o and an_o SHALL be registered and change only on state-transition edges, with no combinational glitches.
REQ-019 Values 0..15 below base_p SHALL use the standard hex pattern (0=7'h40, 1=7'h79, 8=7'h00, A=7'h08).
REQ-020 Snapshot values >= base_p SHALL display a dash, 7'h3F.
REQ-021 With lzb_i=1, digit n (n=4..1) SHALL be blanked (seg_o=7'h7F, an_o bit still low) when its value and every higher digit's value is zero.
REQ-022 Digit 0 SHALL never be blanked.
REQ-023 lzb_i SHALL be sampled with the snapshot.

Reset
REQ-024 While rst_i=1, outputs SHALL be forced asynchronously: an_o=5'b11111, seg_o=7'h7F, frame_o=0.
REQ-025 While rst_i=1, state SHALL be GAP, the prescaler 0, the index 4 (so the next DRIVE is 0), and the snapshot all zeros.
REQ-026 After rst_i deasserts, the first DRIVE SHALL begin gap_p cycles later.
REQ-027 Reset asserted mid-DRIVE SHALL abort the scan, and no partial frame_o SHALL be emitted.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the 16-entry segment table, the dash and blank constants, and the digit-count constant (5).
REQ-029 Decoding SHALL be done in one combinational sub-module, seg7_decode (value, base -> segments), instantiated once on the muxed snapshot digit.

Verification (bench uses scan_div_p=4, gap_p=2)
REQ-030 Reset: assert rst_i mid-DRIVE -> an_o=11111 and seg_o=7F in the same cycle, without waiting for a clock; after release, 2 cycles all-off, then an_o=11110.
REQ-031 Scan: counts 5,4,3,2,1 (count4..count0), lzb_i=0 -> an_o 11110 with seg 79 for 4 cycles, 2 off, then 11101 with digit 2 pattern, etc.; frame_o period 30 cycles.
REQ-032 Snapshot: change count0_i from 1 to 8 while index 2 is driven -> digit 0 shows 79 until the next frame_o, then 00.
REQ-033 Leading zero: counts 0,0,1,0,0 with lzb_i=1 -> digits 4 and 3 show 7F; digits 2, 1 and 0 show 79, 40 and 40.
REQ-034 All zero with lzb_i=1 -> only digit 0 shows 40; with lzb_i=0 all five digits show 40.
REQ-035 Out-of-range: base_p=10 with count2_i=12 -> digit 2 shows 3F; base_p=16 with the same input -> shows the C pattern, 7'h46.
